threshold_bank: RTL and testbench

Runtime-programmable, double-buffered threshold table for the comparator datapath. It holds `DEPTH` threshold words of `WIDTH` bits each, and returns the selected word one clock after a lookup request. New values are staged in a shadow bank and made live atomically on a commit strobe, so a lookup never sees a half-updated table. Reset reloads the factory default thresholds.

---
 rtl/threshold_pkg.sv | 29 ++
 rtl/threshold_regfile.sv | 53 +++++
 rtl/threshold_bank.sv | 148 ++++++++++++++
 tb/tb_threshold_bank.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/threshold_pkg.sv
// threshold_pkg
//   Shared constants for the threshold table:
//     THRESH_W_DEF   - native width of the factory threshold words (28)
//     DEFAULT_THRESH - the four factory threshold words
//     default_entry  - factory value for table entry k, resized to a given width
package threshold_pkg;

   localparam int THRESH_W_DEF = 28;

   localparam logic [THRESH_W_DEF-1:0] DEFAULT_THRESH [0:3] = '{
      28'h96A5A5A, 28'hF0EB45A, 28'h96AAA5A, 28'h555A65A
   };

   // Widest table word default_entry can describe; callers cast the result
   // down (or up, zero-filling) to their own WIDTH.
   localparam int ENTRY_MAX_W = 64;

   // Entry k takes factory word k % 4. Resizing keeps the LSBs: bits at or
   // above 'width' are cleared, narrower words simply lose their top bits.
   function automatic logic [ENTRY_MAX_W-1:0] default_entry(input int k, input int width);
      logic [ENTRY_MAX_W-1:0] v;
      v = ENTRY_MAX_W'(DEFAULT_THRESH[2'(k)]);
      for (int i = 0; i < ENTRY_MAX_W; i++) begin
         if (i >= width) v[i] = 1'b0;
      end
      return v;
   endfunction

endpackage

// File: rtl/threshold_regfile.sv
// threshold_regfile
//   DEPTH x WIDTH register array, reset to the factory thresholds.
//   Ports:
//     clk, rst                     - clock, synchronous active-high reset
//     wr_en, wr_addr, wr_data      - single write port (out-of-range address ignored)
//     load_en, load_data           - whole-array load, takes priority over the write port
//     rd_addr -> rd_data           - asynchronous read (0 for out-of-range address)
//     entries                      - every entry, asynchronously, for bulk copies
module threshold_regfile
   import threshold_pkg::*;
#(
   parameter int WIDTH = THRESH_W_DEF,
   parameter int DEPTH = 4,
   parameter int SEL_W = $clog2(DEPTH)
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        wr_en,
   input  logic [SEL_W-1:0]            wr_addr,
   input  logic [WIDTH-1:0]            wr_data,
   input  logic                        load_en,
   input  logic [DEPTH-1:0][WIDTH-1:0] load_data,
   input  logic [SEL_W-1:0]            rd_addr,
   output logic [WIDTH-1:0]            rd_data,
   output logic [DEPTH-1:0][WIDTH-1:0] entries
);

   logic [DEPTH-1:0][WIDTH-1:0] mem_q;
   logic [DEPTH-1:0][WIDTH-1:0] mem_d;

   always_comb begin
      mem_d = mem_q;
      if (load_en) begin
         mem_d = load_data;
      end else if (wr_en && (32'(wr_addr) < DEPTH)) begin
         mem_d[wr_addr] = wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < DEPTH; k++) begin
            mem_q[k] <= WIDTH'(default_entry(k, WIDTH));
         end
      end else begin
         mem_q <= mem_d;
      end
   end

   assign rd_data = (32'(rd_addr) < DEPTH) ? mem_q[rd_addr] : '0;
   assign entries = mem_q;

endmodule

// File: rtl/threshold_bank.sv
// threshold_bank
//   Runtime-programmable threshold table with a registered 1-cycle lookup.
//   Build option THRESH_SHADOW_EN:
//     defined   - writes go to a shadow bank, 'commit' copies it into the
//                 active bank atomically, 'dirty' flags pending writes
//     undefined - writes go straight to the active bank, 'commit' is
//                 ignored, 'dirty' stays 0
//   Ports:
//     iclk, irst                 - clock, synchronous active-high reset
//     slt, slt_valid             - lookup index and request strobe
//     wr_en, wr_addr, wr_data    - table write
//     commit                     - make the shadow bank live
//     thresh_out, thresh_valid   - looked-up word, and "updated this cycle"
//     sel_err                    - last lookup index was >= DEPTH
//     dirty                      - shadow bank holds uncommitted writes
module threshold_bank
   import threshold_pkg::*;
#(
   parameter int WIDTH = THRESH_W_DEF,
   parameter int DEPTH = 4,
   parameter int SEL_W = $clog2(DEPTH)
) (
   input  logic             iclk,
   input  logic             irst,
   input  logic [SEL_W-1:0] slt,
   input  logic             slt_valid,
   input  logic             wr_en,
   input  logic [SEL_W-1:0] wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             commit,
   output logic [WIDTH-1:0] thresh_out,
   output logic             thresh_valid,
   output logic             sel_err,
   output logic             dirty
);

   logic [WIDTH-1:0]            act_rd;
   logic [DEPTH-1:0][WIDTH-1:0] unused_act_entries;
   logic                        slt_in_range;
   logic                        dirty_d;
   logic                        dirty_q;

   assign slt_in_range = (32'(slt) < DEPTH);

`ifdef THRESH_SHADOW_EN
   logic [DEPTH-1:0][WIDTH-1:0] shd_entries;
   logic [DEPTH-1:0][WIDTH-1:0] commit_data;
   logic [WIDTH-1:0]            unused_shd_rd;
   logic                        wr_in_range;

   assign wr_in_range = wr_en && (32'(wr_addr) < DEPTH);

   threshold_regfile #(.WIDTH(WIDTH), .DEPTH(DEPTH), .SEL_W(SEL_W)) u_shadow (
      .clk       (iclk),
      .rst       (irst),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .load_en   (1'b0),
      .load_data ('0),
      .rd_addr   ('0),
      .rd_data   (unused_shd_rd),
      .entries   (shd_entries)
   );

   // A write landing in the same cycle as a commit must reach the active
   // bank too, so the commit copies the shadow contents with it overlaid.
   always_comb begin
      commit_data = shd_entries;
      if (wr_in_range) commit_data[wr_addr] = wr_data;
   end

   threshold_regfile #(.WIDTH(WIDTH), .DEPTH(DEPTH), .SEL_W(SEL_W)) u_active (
      .clk       (iclk),
      .rst       (irst),
      .wr_en     (1'b0),
      .wr_addr   ('0),
      .wr_data   ('0),
      .load_en   (commit),
      .load_data (commit_data),
      .rd_addr   (slt),
      .rd_data   (act_rd),
      .entries   (unused_act_entries)
   );

   // Commit clears dirty even when a write arrives with it (the write is
   // folded into the commit).
   always_comb begin
      dirty_d = dirty_q;
      if (commit)           dirty_d = 1'b0;
      else if (wr_in_range) dirty_d = 1'b1;
   end
`else
   logic unused_commit;
   assign unused_commit = commit;

   threshold_regfile #(.WIDTH(WIDTH), .DEPTH(DEPTH), .SEL_W(SEL_W)) u_active (
      .clk       (iclk),
      .rst       (irst),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .load_en   (1'b0),
      .load_data ('0),
      .rd_addr   (slt),
      .rd_data   (act_rd),
      .entries   (unused_act_entries)
   );

   assign dirty_d = 1'b0;
`endif

   logic [WIDTH-1:0] thresh_p1_d, thresh_p1_q;
   logic             vld_p1_d,    vld_p1_q;
   logic             sel_err_p1_d, sel_err_p1_q;

   // Lookup reads the active bank before any same-cycle commit lands.
   always_comb begin
      thresh_p1_d  = thresh_p1_q;
      sel_err_p1_d = sel_err_p1_q;
      vld_p1_d     = slt_valid;
      if (slt_valid) begin
         thresh_p1_d  = slt_in_range ? act_rd : '0;
         sel_err_p1_d = !slt_in_range;
      end
   end

   // ---- stage p1: registered lookup result and dirty flag ----
   always_ff @(posedge iclk) begin
      if (irst) begin
         thresh_p1_q  <= '0;
         vld_p1_q     <= 1'b0;
         sel_err_p1_q <= 1'b0;
         dirty_q      <= 1'b0;
      end else begin
         thresh_p1_q  <= thresh_p1_d;
         vld_p1_q     <= vld_p1_d;
         sel_err_p1_q <= sel_err_p1_d;
         dirty_q      <= dirty_d;
      end
   end

   assign thresh_out   = thresh_p1_q;
   assign thresh_valid = vld_p1_q;
   assign sel_err      = sel_err_p1_q;
   assign dirty        = dirty_q;

endmodule

// File: tb/tb_threshold_bank.sv
// tb_threshold_bank
//   Drives threshold_bank (DEPTH=5, WIDTH=28) with the directed scenarios
//   followed by random traffic, comparing every cycle against a table model.
module tb_threshold_bank;

   localparam int WIDTH = 28;
   localparam int DEPTH = 5;
   localparam int SEL_W = 3;

`ifdef THRESH_SHADOW_EN
   localparam bit SHADOW = 1'b1;
`else
   localparam bit SHADOW = 1'b0;
`endif

   logic             iclk = 1'b0;
   logic             irst = 1'b1;
   logic [SEL_W-1:0] slt = '0;
   logic             slt_valid = 1'b0;
   logic             wr_en = 1'b0;
   logic [SEL_W-1:0] wr_addr = '0;
   logic [WIDTH-1:0] wr_data = '0;
   logic             commit = 1'b0;
   logic [WIDTH-1:0] thresh_out;
   logic             thresh_valid;
   logic             sel_err;
   logic             dirty;

   threshold_bank #(.WIDTH(WIDTH), .DEPTH(DEPTH), .SEL_W(SEL_W)) dut (
      .iclk         (iclk),
      .irst         (irst),
      .slt          (slt),
      .slt_valid    (slt_valid),
      .wr_en        (wr_en),
      .wr_addr      (wr_addr),
      .wr_data      (wr_data),
      .commit       (commit),
      .thresh_out   (thresh_out),
      .thresh_valid (thresh_valid),
      .sel_err      (sel_err),
      .dirty        (dirty)
   );

   always #5 iclk = ~iclk;

   int n_vec = 0;
   int n_err = 0;

   logic [27:0] dflt [0:3] = '{28'h96A5A5A, 28'hF0EB45A, 28'h96AAA5A, 28'h555A65A};

   // Reference state: what the table and outputs should be after each edge.
   logic [27:0] act_m [0:DEPTH-1];
   logic [27:0] shd_m [0:DEPTH-1];
   logic [27:0] exp_out;
   logic        exp_vld;
   logic        exp_err;
   logic        exp_dirty;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_edge(input logic r, input logic sv, input logic [2:0] s,
                             input logic we, input logic [2:0] wa, input logic [27:0] wd,
                             input logic cm);
      logic wr_ok;
      if (r) begin
         for (int k = 0; k < DEPTH; k++) begin
            act_m[3'(k)] = dflt[2'(k)];
            shd_m[3'(k)] = dflt[2'(k)];
         end
         exp_out = '0; exp_vld = 1'b0; exp_err = 1'b0; exp_dirty = 1'b0;
      end else begin
         exp_vld = sv;
         if (sv) begin
            if (s < 3'(DEPTH)) begin
               exp_out = act_m[s];
               exp_err = 1'b0;
            end else begin
               exp_out = '0;
               exp_err = 1'b1;
            end
         end
         wr_ok = we && (wa < 3'(DEPTH));
         if (SHADOW) begin
            if (wr_ok) shd_m[wa] = wd;
            if (cm) begin
               act_m = shd_m;
               exp_dirty = 1'b0;
            end else if (wr_ok) begin
               exp_dirty = 1'b1;
            end
         end else if (wr_ok) begin
            act_m[wa] = wd;
         end
      end
   endtask

   task automatic cyc(input logic r, input logic sv, input logic [2:0] s,
                      input logic we, input logic [2:0] wa, input logic [27:0] wd,
                      input logic cm);
      irst = r; slt_valid = sv; slt = s;
      wr_en = we; wr_addr = wa; wr_data = wd; commit = cm;
      @(posedge iclk);
      model_edge(r, sv, s, we, wa, wd, cm);
      #1;
      check_eq("thresh_out",   64'(thresh_out),   64'(exp_out));
      check_eq("thresh_valid", 64'(thresh_valid), 64'(exp_vld));
      check_eq("sel_err",      64'(sel_err),      64'(exp_err));
      check_eq("dirty",        64'(dirty),        64'(exp_dirty));
   endtask

   task automatic lookup(input logic [2:0] s);
      cyc(1'b0, 1'b1, s, 1'b0, 3'd0, 28'h0, 1'b0);
   endtask

   task automatic idle();
      cyc(1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 28'h0, 1'b0);
   endtask

   initial begin
      // Reset and factory defaults
      cyc(1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 28'h0, 1'b0);
      cyc(1'b1, 1'b1, 3'd1, 1'b1, 3'd1, 28'h1, 1'b1);
      lookup(3'd1);
      check_eq("dflt_1_literal", 64'(thresh_out), 64'h0F0EB45A);
      lookup(3'd0); lookup(3'd2); lookup(3'd3); lookup(3'd4);
      idle();

      // Staged write, then commit
      cyc(1'b0, 1'b0, 3'd0, 1'b1, 3'd2, 28'h1234567, 1'b0);
      lookup(3'd2);
      cyc(1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 28'h0, 1'b1);
      lookup(3'd2);

      // Write + commit + lookup in one cycle
      cyc(1'b0, 1'b1, 3'd3, 1'b1, 3'd3, 28'hABCDEF0, 1'b1);
      lookup(3'd3);

      // Range handling
      lookup(3'd7);
      check_eq("oob_sel_err_literal", 64'(sel_err), 64'h1);
      lookup(3'd5);
      cyc(1'b0, 1'b0, 3'd0, 1'b1, 3'd6, 28'h5555555, 1'b0);
      idle();
      lookup(3'd4);

      // Reset discards pending writes
      cyc(1'b0, 1'b0, 3'd0, 1'b1, 3'd0, 28'h0000001, 1'b0);
      cyc(1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 28'h0, 1'b0);
      lookup(3'd0);

      // Write then immediate lookup, then commit, then lookup
      cyc(1'b0, 1'b0, 3'd0, 1'b1, 3'd1, 28'h7777777, 1'b0);
      lookup(3'd1);
      cyc(1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 28'h0, 1'b1);
      lookup(3'd1);
      cyc(1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 28'h0, 1'b1);

      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         cyc(($urandom_range(0, 63) == 0),
             ($urandom_range(0, 1) == 1),
             3'($urandom_range(0, 7)),
             ($urandom_range(0, 2) == 0),
             3'($urandom_range(0, 7)),
             28'($urandom),
             ($urandom_range(0, 5) == 0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
